// File: rtl/key_cmd_pkg.sv
// Shared constants and types for the key command conditioner: channel indices,
// default 50 MHz cycle counts and the debounced key state encoding.
package key_cmd_pkg;

    localparam int CH_LEFT  = 0;
    localparam int CH_RIGHT = 1;
    localparam int CH_START = 2;
    localparam int NUM_CH   = 3;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int DEFAULT_REPEAT_CYCLES   = 25000000;

    typedef enum logic {
        KEY_RELEASED = 1'b0,
        KEY_PRESSED  = 1'b1
    } key_state_e;

endpackage

// File: rtl/key_channel.sv
// One push-button channel: 2-flop synchroniser, debouncer, press strobe and,
// when KEY_AUTO_REPEAT_EN is defined and REPEAT_EN is set, a hold-to-repeat counter.
module key_channel
    import key_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic pressed,
    output logic event_o
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    key_state_e deb_q, deb_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic       event_q, event_d;
    logic       differ_s;
    logic       flip_s;
    logic       rep_evt_s;

    // Synchronise, debounce and form the press/repeat event strobe.
    always_comb begin
        sync1_d  = key_n;
        sync2_d  = sync1_q;
        differ_s = (~sync2_q) != (deb_q == KEY_PRESSED);
        flip_s   = differ_s && (cnt_q == DEB_LAST);
        deb_d    = deb_q;
        cnt_d    = {DW{1'b0}};
        if (flip_s) begin
            deb_d = (deb_q == KEY_PRESSED) ? KEY_RELEASED : KEY_PRESSED;
            cnt_d = {DW{1'b0}};
        end else if (differ_s) begin
            cnt_d = cnt_q + DW'(1);
        end else begin
            cnt_d = {DW{1'b0}};
        end
        event_d = (flip_s && (deb_q == KEY_RELEASED)) || rep_evt_s;
    end

`ifdef KEY_AUTO_REPEAT_EN
    if (REPEAT_EN) begin : g_repeat
        localparam int RW = $clog2(REPEAT_CYCLES + 1);
        localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
        logic [RW-1:0] rep_q, rep_d;
        logic          rep_evt_d;

        // Count hold time; restarts on the press edge and whenever released.
        always_comb begin
            rep_d     = rep_q;
            rep_evt_d = 1'b0;
            if ((deb_q == KEY_RELEASED) || flip_s) begin
                rep_d = {RW{1'b0}};
            end else if (rep_q == REP_LAST) begin
                rep_d     = {RW{1'b0}};
                rep_evt_d = 1'b1;
            end else begin
                rep_d = rep_q + RW'(1);
            end
        end

        // Repeat counter state.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rep_q <= {RW{1'b0}};
            end else begin
                rep_q <= rep_d;
            end
        end

        assign rep_evt_s = rep_evt_d;
    end else begin : g_no_repeat
        assign rep_evt_s = 1'b0;
    end
`else
    assign rep_evt_s = 1'b0;
`endif

    // Channel state registers; reset forces a fresh debounce from "released".
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            deb_q   <= KEY_RELEASED;
            cnt_q   <= {DW{1'b0}};
            event_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            event_q <= event_d;
        end
    end

    assign pressed = (deb_q == KEY_PRESSED);
    assign event_o = event_q;

endmodule

// File: rtl/key_command_conditioner.sv
// Turns raw active-low DE1-SoC keys into pending left/right commands and a start pulse.
// Hold-to-repeat on left/right is built only when KEY_AUTO_REPEAT_EN is defined.
module key_command_conditioner
    import key_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_left_n,
    input  logic       key_right_n,
    input  logic       key_start_n,
    input  logic       accept,
    output logic       left,
    output logic       right,
    output logic       start,
    output logic [2:0] held
);

    logic [NUM_CH-1:0] event_s;
    logic [NUM_CH-1:0] pressed_s;
    logic pend_l_q, pend_l_d;
    logic pend_r_q, pend_r_d;
    logic start_q, start_d;

    key_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES),
        .REPEAT_EN      (1'b1)
    ) u_left (
        .clk    (clk),
        .reset  (reset),
        .key_n  (key_left_n),
        .pressed(pressed_s[CH_LEFT]),
        .event_o(event_s[CH_LEFT])
    );

    key_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES),
        .REPEAT_EN      (1'b1)
    ) u_right (
        .clk    (clk),
        .reset  (reset),
        .key_n  (key_right_n),
        .pressed(pressed_s[CH_RIGHT]),
        .event_o(event_s[CH_RIGHT])
    );

    key_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES),
        .REPEAT_EN      (1'b0)
    ) u_start (
        .clk    (clk),
        .reset  (reset),
        .key_n  (key_start_n),
        .pressed(pressed_s[CH_START]),
        .event_o(event_s[CH_START])
    );

    // Pending command update: accept drops both, a new event overrides accept,
    // and left takes priority when both keys fire together.
    always_comb begin
        if (accept) begin
            pend_l_d = 1'b0;
            pend_r_d = 1'b0;
        end else begin
            pend_l_d = pend_l_q;
            pend_r_d = pend_r_q;
        end
        if (event_s[CH_LEFT]) begin
            pend_l_d = 1'b1;
        end else if (event_s[CH_RIGHT]) begin
            pend_r_d = 1'b1;
        end else begin
            pend_l_d = pend_l_d;
        end
        start_d = event_s[CH_START];
    end

    // Command registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_l_q <= 1'b0;
            pend_r_q <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            pend_l_q <= pend_l_d;
            pend_r_q <= pend_r_d;
            start_q  <= start_d;
        end
    end

    assign left  = pend_l_q;
    assign right = pend_r_q & ~pend_l_q;
    assign start = start_q;
    assign held  = pressed_s;

endmodule

// File: tb/tb_key_command_conditioner.sv
// Randomised + directed bench for key_command_conditioner; a reference model pushes
// expected outputs per cycle into a scoreboard queue that a negedge monitor checks.
module tb_key_command_conditioner;

    localparam int D = 4;
    localparam int R = 20;
`ifdef KEY_AUTO_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] keys_n;
    logic       acc;
    logic       left, right, start;
    logic [2:0] held;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       l;
        logic       r;
        logic       s;
        logic [2:0] h;
    } exp_t;
    exp_t exp_q[$];

    key_command_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .key_left_n (keys_n[0]),
        .key_right_n(keys_n[1]),
        .key_start_n(keys_n[2]),
        .accept     (acc),
        .left       (left),
        .right      (right),
        .start      (start),
        .held       (held)
    );

    always #5 clk = ~clk;

    // Reference model: a key state flips once D consecutive synchronised samples
    // (raw samples delayed by two edges) disagree with it.
    bit st[3];
    bit hist[3][64];
    bit evp[3];
    int mpress[3];
    bit pl, pr;
    int cyc;

    always @(posedge clk) begin
        exp_t e;
        bit ev[3];
        bit raw[3];
        bit all_diff;
        e = '0;
        if (!rst_n) begin
            for (int ch = 0; ch < 3; ch++) begin
                st[ch] = 1'b0;
                evp[ch] = 1'b0;
                mpress[ch] = 0;
                for (int k = 0; k < 64; k++) hist[ch][k] = 1'b0;
            end
            pl = 1'b0;
            pr = 1'b0;
            cyc = 100;
        end else begin
            cyc++;
            for (int ch = 0; ch < 3; ch++) raw[ch] = ~keys_n[ch];
            if (acc) begin
                pl = 1'b0;
                pr = 1'b0;
            end
            if (evp[0]) pl = 1'b1;
            else if (evp[1]) pr = 1'b1;
            e.s = evp[2];
            for (int ch = 0; ch < 3; ch++) begin
                all_diff = 1'b1;
                for (int k = 2; k <= D + 1; k++)
                    if (hist[ch][(cyc - k) % 64] == st[ch]) all_diff = 1'b0;
                ev[ch] = 1'b0;
                if (all_diff) begin
                    if (!st[ch]) begin
                        ev[ch] = 1'b1;
                        mpress[ch] = cyc;
                    end
                    st[ch] = ~st[ch];
                end else if (st[ch] && ch != 2 && REP && ((cyc - mpress[ch]) % R == 0)) begin
                    ev[ch] = 1'b1;
                end
                hist[ch][cyc % 64] = raw[ch];
            end
            for (int ch = 0; ch < 3; ch++) evp[ch] = ev[ch];
            e.l = pl;
            e.r = pr & ~pl;
            e.h = {st[2], st[1], st[0]};
        end
        exp_q.push_back(e);
    end

    bit win_l = 1'b0, win_s = 1'b0;
    int left_cnt = 0, start_cnt = 0;

    // Scoreboard monitor, sampling mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty at t=%0t", $time);
        end else begin
            e = exp_q.pop_front();
            if (!rst_n) e = '0;
            if ({left, right, start, held} !== {e.l, e.r, e.s, e.h}) begin
                errors++;
                $display("FAIL outputs t=%0t got l=%b r=%b s=%b held=%b expected l=%b r=%b s=%b held=%b",
                         $time, left, right, start, held, e.l, e.r, e.s, e.h);
            end
        end
        checks++;
        if (left && right) begin
            errors++;
            $display("FAIL left_right_exclusive t=%0t got l=%b r=%b expected not both", $time, left, right);
        end
        if (win_l && left) left_cnt++;
        if (win_s && start) start_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    int rem[3];

    initial begin
        rst_n  = 1'b0;
        keys_n = 3'b111;
        acc    = 1'b0;
        tick(3);
        rst_n = 1'b1;

        // Left held from edge 0, no accept.
        keys_n[0] = 1'b0;
        tick(40);
        keys_n[0] = 1'b1;
        tick(15);
        acc = 1'b1;
        tick(1);
        acc = 1'b0;
        tick(3);

        // Short right glitches never debounce.
        repeat (10) begin
            keys_n[1] = 1'b0;
            tick(3);
            keys_n[1] = 1'b1;
            tick(3);
        end
        tick(10);

        // Accept coincident with the press event.
        keys_n[0] = 1'b0;
        tick(6);
        acc = 1'b1;
        tick(1);
        acc = 1'b0;
        keys_n[0] = 1'b1;
        tick(5);
        acc = 1'b1;
        tick(1);
        acc = 1'b0;
        tick(15);

        // Hold left with accept every cycle: one press plus two repeats.
        acc = 1'b1;
        tick(2);
        left_cnt = 0;
        win_l = 1'b1;
        keys_n[0] = 1'b0;
        tick(55);
        keys_n[0] = 1'b1;
        tick(25);
        win_l = 1'b0;
        acc = 1'b0;
        check_cnt("hold_repeat_left_pulses", left_cnt, REP ? 3 : 1);

        // Simultaneous left/right.
        keys_n[1:0] = 2'b00;
        tick(12);
        keys_n[1:0] = 2'b11;
        tick(10);
        acc = 1'b1;
        tick(1);
        acc = 1'b0;
        tick(30);

        // Start held, then reset mid-hold.
        start_cnt = 0;
        win_s = 1'b1;
        keys_n[2] = 1'b0;
        tick(50);
        win_s = 1'b0;
        check_cnt("start_single_pulse", start_cnt, 1);
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        start_cnt = 0;
        win_s = 1'b1;
        tick(20);
        win_s = 1'b0;
        check_cnt("start_after_reset_pulse", start_cnt, 1);
        keys_n[2] = 1'b1;
        tick(15);

        // Random keys with random hold lengths, random accept and rare resets.
        for (int ch = 0; ch < 3; ch++) rem[ch] = $urandom_range(1, 40);
        repeat (3000) begin
            for (int ch = 0; ch < 3; ch++) begin
                if (rem[ch] == 0) begin
                    keys_n[ch] = ~keys_n[ch];
                    rem[ch] = $urandom_range(1, 45);
                end else begin
                    rem[ch]--;
                end
            end
            acc = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                tick(2);
                rst_n = 1'b1;
            end
            tick(1);
        end
        keys_n = 3'b111;
        acc = 1'b0;
        tick(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
